// File: rtl/pce_line_doubler.sv
// Scan doubler for the HuC6260 VCE: captures each 15.7 kHz line into a ping-pong
// buffer and replays it twice at 31.4 kHz with VGA sync, data enable and pixel strobe.
module pce_line_doubler #(
    parameter int unsigned MAX_W     = 512,
    parameter int unsigned HALF_LINE = 1365,
    parameter int unsigned OUT_DIV   = 2,
    parameter int unsigned ACT_START = 200,
    parameter int unsigned ACT_LEN   = 512,
    parameter int unsigned HS_LEN    = 160
) (
    input  logic       clk,
    input  logic       reset_N,
    input  logic       pix_en,
    input  logic       pix_valid,
    input  logic [7:0] pix_r,
    input  logic [7:0] pix_g,
    input  logic [7:0] pix_b,
    input  logic       hsync_n,
    input  logic       vsync_n,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_de,
    output logic       vga_pix_en
);
    localparam int unsigned AW      = $clog2(MAX_W);
    localparam int unsigned LW      = AW + 1;
    localparam int unsigned TW      = $clog2(HALF_LINE);
    localparam int unsigned DW      = 24;
    localparam int unsigned ACT_END = ACT_START + ACT_LEN * OUT_DIV;

    typedef enum logic [1:0] {IDLE, LINE0, LINE1} state_t;

    logic [DW-1:0]         mem [2*MAX_W];
    logic                  hs_prev;
    logic                  wr_bank;
    logic                  rd_bank;
    logic [LW-1:0]         wr_addr;
    logic [LW-1:0]         rd_addr;
    logic [1:0][LW-1:0]    line_len;
    state_t                state;
    state_t                state_nxt;
    logic [TW-1:0]         timer;
    logic [TW-1:0]         timer_nxt;
    logic                  vs_int;

    logic                  hs_fall_c;
    logic                  wr_en_c;
    logic [LW-1:0]         wr_idx_c;
    logic [LW-1:0]         rd_idx_c;
    logic                  line_start_c;
    logic                  active_c;
    logic [31:0]           t32_c;
    logic                  hs_c;
    logic                  de_c;
    logic                  strobe_c;
    logic                  in_len_c;

    // Capture side: the coincident pixel of an hsync edge goes to address 0 of the new bank.
    always_comb begin
        hs_fall_c = hs_prev & ~hsync_n;
        wr_en_c   = pix_en & pix_valid & (hs_fall_c | (wr_addr < LW'(MAX_W)));
        wr_idx_c  = hs_fall_c ? {~wr_bank, AW'(0)} : {wr_bank, wr_addr[AW-1:0]};
        rd_idx_c  = {rd_bank, rd_addr[AW-1:0]};
    end

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            hs_prev  <= 1'b0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b1;
            wr_addr  <= '0;
            line_len <= '0;
        end else begin
            hs_prev <= hsync_n;
            if (hs_fall_c) begin
                line_len[wr_bank] <= wr_addr;
                rd_bank           <= wr_bank;
                wr_bank           <= ~wr_bank;
                wr_addr           <= LW'(wr_en_c);
            end else if (wr_en_c) begin
                wr_addr <= wr_addr + LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_idx_c] <= {pix_r, pix_g, pix_b};
        end
    end

    // Output line sequencer: an hsync edge always restarts LINE0, even mid-line.
    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer;
        line_start_c = 1'b0;
        if (hs_fall_c) begin
            state_nxt    = LINE0;
            timer_nxt    = '0;
            line_start_c = 1'b1;
        end else begin
            case (state)
                LINE0: begin
                    if (timer == TW'(HALF_LINE - 1)) begin
                        state_nxt    = LINE1;
                        timer_nxt    = '0;
                        line_start_c = 1'b1;
                    end else begin
                        timer_nxt = timer + TW'(1);
                    end
                end
                LINE1: begin
                    if (timer == TW'(HALF_LINE - 1)) begin
                        state_nxt = IDLE;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer + TW'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        active_c = (state != IDLE);
        t32_c    = 32'(timer);
        hs_c     = active_c && (t32_c < HS_LEN);
        de_c     = active_c && (t32_c >= ACT_START) && (t32_c < ACT_END);
        strobe_c = de_c && (((t32_c - ACT_START) % OUT_DIV) == 32'd0);
        in_len_c = rd_addr < line_len[rd_bank];
    end

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state   <= IDLE;
            timer   <= '0;
            vs_int  <= 1'b0;
            rd_addr <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            if (line_start_c) begin
                vs_int  <= ~vsync_n;
                rd_addr <= '0;
            end else if (strobe_c) begin
                rd_addr <= rd_addr + LW'(1);
            end
        end
    end

    // Registered outputs; colour holds for the whole output pixel and is black outside the window.
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            vga_r      <= '0;
            vga_g      <= '0;
            vga_b      <= '0;
            vga_hs     <= 1'b0;
            vga_vs     <= 1'b0;
            vga_de     <= 1'b0;
            vga_pix_en <= 1'b0;
        end else begin
            vga_hs     <= hs_c;
            vga_vs     <= active_c & vs_int;
            vga_de     <= de_c;
            vga_pix_en <= strobe_c;
            if (strobe_c) begin
                {vga_r, vga_g, vga_b} <= in_len_c ? mem[rd_idx_c] : DW'(0);
            end else if (!de_c) begin
                {vga_r, vga_g, vga_b} <= DW'(0);
            end
        end
    end
endmodule

// File: tb/tb_pce_line_doubler.sv
// Bench for pce_line_doubler: randomized VCE lines checked cycle by cycle against
// a line-level model (captured pixel queues, time since last hsync edge).
`timescale 1ns/1ps
module tb_pce_line_doubler;
    localparam int H         = 1365;
    localparam int MAXW      = 512;
    localparam int ACT_START = 200;
    localparam int ACT_LEN   = 512;
    localparam int OUT_DIV   = 2;
    localparam int HS_LEN    = 160;

    logic       clk = 1'b0;
    logic       reset_N = 1'b1;
    logic       pix_en = 1'b0;
    logic       pix_valid = 1'b0;
    logic [7:0] pix_r = 8'd0;
    logic [7:0] pix_g = 8'd0;
    logic [7:0] pix_b = 8'd0;
    logic       hsync_n = 1'b1;
    logic       vsync_n = 1'b1;
    logic [7:0] vga_r;
    logic [7:0] vga_g;
    logic [7:0] vga_b;
    logic       vga_hs;
    logic       vga_vs;
    logic       vga_de;
    logic       vga_pix_en;

    pce_line_doubler dut (
        .clk(clk), .reset_N(reset_N), .pix_en(pix_en), .pix_valid(pix_valid),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .hsync_n(hsync_n), .vsync_n(vsync_n),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
        .vga_de(vga_de), .vga_pix_en(vga_pix_en)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    string       phase = "init";

    // Reference state: pixels of the line being captured, and the line being replayed.
    logic [23:0] cur[$];
    logic [23:0] played[$];
    bit          prev_m = 1'b0;
    bit          have_fall = 1'b0;
    int          f_cyc = 0;
    bit          vs0 = 1'b0;
    bit          vs1 = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({vga_hs, vga_vs, vga_de, vga_pix_en, vga_r, vga_g, vga_b});
    endfunction

    // Expected output after the clock edge of cycle i, from falls strictly before i.
    function automatic logic [31:0] model_out(input int i);
        int k, t, j;
        bit hs, vs, de, pe;
        logic [23:0] px;
        if (!have_fall) return 32'd0;
        k = i - f_cyc - 1;
        if (k >= 2 * H) return 32'd0;
        t  = k % H;
        hs = (t < HS_LEN);
        vs = (k < H) ? vs0 : vs1;
        de = (t >= ACT_START) && (t < ACT_START + ACT_LEN * OUT_DIV);
        pe = de && (((t - ACT_START) % OUT_DIV) == 0);
        px = 24'd0;
        if (de) begin
            j = (t - ACT_START) / OUT_DIV;
            if (j < played.size()) px = played[j];
        end
        return 32'({hs, vs, de, pe, px});
    endfunction

    task automatic tick(input bit hs_n, input bit vs_n, input bit en, input bit valid,
                        input logic [23:0] px);
        logic [31:0] exp;
        hsync_n   = hs_n;
        vsync_n   = vs_n;
        pix_en    = en;
        pix_valid = valid;
        {pix_r, pix_g, pix_b} = px;
        @(posedge clk);
        exp = model_out(cyc);
        if (prev_m && !hs_n) begin
            played = cur;
            cur.delete();
            vs0       = !vs_n;
            f_cyc     = cyc;
            have_fall = 1'b1;
        end else if (have_fall && (cyc - f_cyc - 1 == H - 1)) begin
            vs1 = !vs_n;
        end
        if (en && valid && cur.size() < MAXW) cur.push_back(px);
        prev_m = hs_n;
        @(negedge clk);
        check(phase, outs(), exp);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) tick(1'b1, 1'b1, 1'b0, 1'b0, 24'($urandom));
    endtask

    // One input line: hsync low for 20 clk from cycle 0, valid pixels every per clk from cycle 30.
    task automatic run_line(input int len, input int npix, input int per, input bit ramp,
                            input bit coinc, input int vlo, input int vhi);
        bit hs_n, vs_n, en, valid;
        logic [23:0] px;
        int idx;
        for (int c = 0; c < len; c++) begin
            hs_n  = (c >= 20);
            vs_n  = !((c >= vlo) && (c <= vhi));
            px    = 24'($urandom);
            en    = 1'b0;
            valid = 1'b0;
            idx   = (c - 30) / per;
            if (coinc && c == 0) begin
                en    = 1'b1;
                valid = 1'b1;
            end else if (c >= 30 && ((c - 30) % per) == 0 && idx < npix) begin
                en    = 1'b1;
                valid = 1'b1;
                if (ramp) px[23:16] = 8'(idx);
            end else if ($urandom_range(0, 7) == 0) begin
                en = 1'b1;
            end else begin
                valid = 1'($urandom);
            end
            tick(hs_n, vs_n, en, valid, px);
        end
    endtask

    task automatic do_reset();
        reset_N   = 1'b0;
        pix_en    = 1'b0;
        pix_valid = 1'b0;
        hsync_n   = 1'b1;
        vsync_n   = 1'b1;
        #1;
        check("reset_async", outs(), 32'd0);
        repeat (3) @(negedge clk);
        check("reset_hold", outs(), 32'd0);
        reset_N = 1'b1;
        have_fall = 1'b0;
        prev_m    = 1'b0;
        cur.delete();
        played.delete();
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        phase = "idle_after_reset";  idle(50);
        phase = "first_line_black";  run_line(2 * H, 256, 4, 1'b1, 1'b0, -1, -1);
        phase = "ramp_replay";       run_line(2 * H, 256, 4, 1'b1, 1'b0, -1, -1);
        phase = "overflow_capture";  run_line(2 * H, 600, 4, 1'b1, 1'b0, -1, -1);
        phase = "short_line";        run_line(500, 100, 4, 1'b0, 1'b0, -1, -1);
        phase = "coinc_vs_line1";    run_line(2 * H, 80, 4, 1'b0, 1'b1, H - 5, H + 5);
        phase = "missing_hsync";     run_line(4 * H + 100, 50, 8, 1'b0, 1'b0, -1, -1);
        phase = "vs_line0";          run_line(2 * H, 300, 4, 1'b0, 1'b0, 0, 10);
        phase = "pre_reset_partial"; run_line(1000, 200, 4, 1'b0, 1'b0, -1, -1);
        do_reset();
        phase = "idle_after_reset2"; idle(50);
        phase = "black_after_reset"; run_line(2 * H, 256, 4, 1'b1, 1'b0, -1, -1);
        phase = "replay_after_reset"; run_line(2 * H, 128, 4, 1'b0, 1'b0, -1, -1);
        for (int n = 0; n < 3; n++) begin
            int len, vlo;
            len   = int'($urandom_range(1500, 3200));
            vlo   = int'($urandom_range(0, 2999));
            phase = "random_line";
            run_line(len, int'($urandom_range(0, 300)), 4, 1'b0, 1'(n == 1),
                     vlo, vlo + int'($urandom_range(0, 1500)));
        end
        phase = "final_replay";      run_line(2 * H, 0, 4, 1'b0, 1'b0, -1, -1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
